// File: rtl/fp_decode_arbiter.sv
// Two-requester round-robin front end sharing one IEEE-754 single to Q16.16 decoder.
// Operands are registered, decoded next cycle and held until the consumer takes them.
module fp_decode_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] fp0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] fp1,
  output logic        ack1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_id,
  output logic        res_ovf,
  output logic        busy,
  output logic [15:0] conv_count
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] data_q, data_d;
  logic        id_q, id_d;
  logic        ovf_q, ovf_d;
  logic        valid_q, valid_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic        gnt1;
  logic [7:0]  dec_exp;
  logic [63:0] dec_mag;
  logic [31:0] dec_val;

  // Decoder: magnitude = mantissa * 2^(exp-150+16), truncated toward zero
  always_comb begin
    dec_exp = op_q[30:23];
    dec_mag = {40'd0, (dec_exp != 8'd0), op_q[22:0]};
    if (dec_exp >= 8'd134) begin
      dec_mag = dec_mag << (dec_exp - 8'd134);
    end else begin
      dec_mag = dec_mag >> (8'd134 - dec_exp);
    end
    dec_val = op_q[31] ? (32'd0 - dec_mag[31:0]) : dec_mag[31:0];
  end

  // Tie goes to the requester not granted last
  assign gnt1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    id_d    = id_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          op_d    = gnt1 ? fp1 : fp0;
          id_d    = gnt1;
          last_d  = gnt1;
          ack1_d  = gnt1;
          ack0_d  = ~gnt1;
          state_d = CONV;
        end
      end
      CONV: begin
        data_d  = dec_val;
        ovf_d   = (op_q[30:23] >= 8'd142);
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          valid_d = 1'b0;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 32'd0;
      data_q  <= 32'd0;
      id_q    <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign res_valid  = valid_q;
  assign res_data   = data_q;
  assign res_id     = id_q;
  assign res_ovf    = ovf_q;
  assign busy       = (state_q != IDLE);
  assign conv_count = cnt_q;

endmodule

// File: doc/fp_decode_arbiter.md
FP_DECODE_ARBITER -- requirements
Module: fp_decode_arbiter

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide port: req0  input  1  requester 0 conversion request, held until ack0.
REQ-004 SHALL provide port: fp0  input  32  requester 0 IEEE-754 single operand, stable while req0 high.
REQ-005 SHALL provide port: ack0  output  1  one-cycle pulse; fp0 captured.
REQ-006 SHALL provide port: req1  input  1  requester 1 conversion request, held until ack1.
REQ-007 SHALL provide port: fp1  input  32  requester 1 operand, stable while req1 high.
REQ-008 SHALL provide port: ack1  output  1  one-cycle pulse; fp1 captured.
REQ-009 SHALL provide port: res_valid  output  1  result available.
REQ-010 SHALL provide port: res_ready  input  1  consumer accepts result.
REQ-011 SHALL provide port: res_data  output  32  signed Q16.16 fixed-point result.
REQ-012 SHALL provide port: res_id  output  1  requester index of res_data.
REQ-013 SHALL provide port: res_ovf  output  1  operand magnitude outside Q16.16 range.
REQ-014 SHALL provide port: busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL provide port: conv_count  output  16  number of results delivered, saturating.

Function
REQ-016 SHALL share one FP-to-Q16.16 conversion datapath (existing Decoder, combinational) between both requesters; the datapath input is the internal operand register only.
REQ-017 SHALL implement FSM states IDLE, CONV, HOLD.
REQ-018 In IDLE with any req high: SHALL grant one requester, latch its operand into op_reg, record res_id, pulse its ack for exactly one cycle, move to CONV.
REQ-019 Arbitration SHALL be round-robin: on simultaneous req0 and req1, grant the requester not granted last; last-granted pointer resets to 1 (req0 wins first tie).
REQ-020 In IDLE with no req: SHALL stay in IDLE, no ack.
REQ-021 In CONV: SHALL register the datapath output into res_data, compute res_ovf, set res_valid, move to HOLD (unconditionally, one cycle).
REQ-022 res_ovf SHALL be 1 iff operand exponent field >= 142 (|x| >= 32768.0, including Inf/NaN); res_data SHALL still be the raw datapath output.
REQ-023 In HOLD: res_valid, res_data, res_id, res_ovf SHALL stay constant until a cycle with res_valid and res_ready both high; on that edge res_valid clears, conv_count increments, FSM returns to IDLE.
REQ-024 Latency: req sampled at edge N -> ack high N..N+1 -> res_valid high after edge N+1; minimum 3 cycles per conversion (no back-to-back grant in HOLD-exit cycle).
REQ-025 reqs SHALL be ignored in CONV and HOLD; a requester keeps req high until its ack and SHALL drop it the cycle after ack; a req still high in a later IDLE cycle is a new request.
REQ-026 conv_count SHALL saturate at 16'hFFFF (no wrap).
REQ-027 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-028 While rst high: state IDLE, op_reg 0, res_data 0, res_id 0, res_ovf 0, res_valid 0, ack0 0, ack1 0, busy 0, conv_count 0, pointer 1; effective immediately, independent of clk.
REQ-029 Reset asserted mid-conversion (CONV or HOLD) SHALL discard the pending result without ack or count; first post-reset tie goes to req0.

Verification
REQ-030 req0, fp0=32'h3F800000 (1.0), res_ready=1 -> ack0 one cycle, res_data=32'h00010000, res_id=0, res_ovf=0, conv_count=1.
REQ-031 req1, fp1=32'hC0200000 (-2.5) -> res_data=32'hFFFD8000, res_id=1; fp=32'h3F000000 -> 32'h00008000.
REQ-032 req0 and req1 held together from reset, res_ready=1 -> grants alternate 0,1,0,1; never both acks high; each conversion 3 cycles.
REQ-033 fp0=32'h47000000 (32768.0) -> res_ovf=1, res_data=32'h80000000; fp0=32'h46FFFE00 -> res_ovf=0, res_data=32'h7FFF0000.
REQ-034 res_ready=0 for 10 cycles in HOLD with req1 pulsing -> outputs stable, no ack1, busy=1; res_ready=1 -> single handshake, count +1.
REQ-035 rst asserted in HOLD -> res_valid 0 immediately, conv_count unchanged from prior value reset to 0, next tie grants req0.
